// File: rtl/fifo_burst_reader.sv
// Read-side burst engine for a synchronous FIFO: pops exactly N words and streams
// them out through a 2-entry skid buffer that absorbs FIFO read latency and back-pressure.
//
// state | meaning
// IDLE  | waiting for a burst request; req_ready high
// READ  | issuing pops until pop_left reaches 0
// DRAIN | no pops; waiting for the buffered words to be accepted downstream
// DONE  | one-cycle completion pulse, then back to IDLE
module fifo_burst_reader #(
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [LEN_WIDTH-1:0]  req_len,
  output logic                  fifo_pop,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  input  logic                  fifo_empty,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]            state;
  logic [1:0]            state_nxt;
  logic [LEN_WIDTH-1:0]  pop_left;
  logic [LEN_WIDTH-1:0]  out_left;
  logic [1:0]            occ;
  logic                  inflight;
  logic [DATA_WIDTH-1:0] buf_mem [2];
  logic                  head;
  logic                  tail;
  logic                  busy_q;
  logic                  done_q;
  logic                  accept;
  logic                  out_hs;
  logic [2:0]            pending;

  assign req_ready = reset && (state == S_IDLE);
  assign accept    = req_valid && req_ready;

  assign out_valid = (occ != 2'd0);
  assign out_data  = buf_mem[head];
  assign out_last  = out_valid && (out_left == LEN_WIDTH'(1));
  assign out_hs    = out_valid && out_ready;
  assign busy      = busy_q;
  assign done      = done_q;

  // Words already owed to the buffer after this cycle's consume; keeps occ <= 2.
  assign pending  = {1'b0, occ} + {2'b00, inflight} - {2'b00, out_hs};
  assign fifo_pop = reset && (state == S_READ) && (pop_left != '0) &&
                    !fifo_empty && (pending < 3'd2);

  // Tail follows the head by the current occupancy; capture never happens at occ==2.
  assign tail = head ^ occ[0];

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept) state_nxt = (req_len == '0) ? S_DONE : S_READ;
      end
      S_READ: begin
        if (fifo_pop && (pop_left == LEN_WIDTH'(1))) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (out_hs && (out_left == LEN_WIDTH'(1))) state_nxt = S_DONE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= S_IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pop_left   <= '0;
      out_left   <= '0;
      inflight   <= 1'b0;
      occ        <= 2'd0;
      head       <= 1'b0;
      buf_mem[0] <= '0;
      buf_mem[1] <= '0;
    end else begin
      state    <= state_nxt;
      busy_q   <= (state_nxt != S_IDLE);
      done_q   <= (state_nxt == S_DONE);
      inflight <= fifo_pop;

      if (accept) begin
        pop_left <= req_len;
        out_left <= req_len;
      end else begin
        if (fifo_pop) pop_left <= pop_left - LEN_WIDTH'(1);
        if (out_hs)   out_left <= out_left - LEN_WIDTH'(1);
      end

      if (inflight) buf_mem[tail] <= fifo_rd_data;
      if (out_hs)   head <= ~head;
      occ <= occ + {1'b0, inflight} - {1'b0, out_hs};
    end
  end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed self-checking bench for fifo_burst_reader with a behavioural FIFO model
// (registered read data, combinational empty flag).
module tb_fifo_burst_reader;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [7:0]  req_len = '0;
  logic        fifo_pop;
  logic [31:0] fifo_rd_data = '0;
  logic        fifo_empty;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_data;
  logic        out_last;
  logic        busy;
  logic        done;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [31:0] fmem [64];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int pop_total = 0;
  int underflow = 0;

  always #5 clk = ~clk;

  fifo_burst_reader #(.DATA_WIDTH(32), .LEN_WIDTH(8)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_len(req_len),
    .fifo_pop(fifo_pop), .fifo_rd_data(fifo_rd_data), .fifo_empty(fifo_empty),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy), .done(done)
  );

  assign fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (fifo_pop) begin
      if (wr_ptr == rd_ptr) underflow <= underflow + 1;
      fifo_rd_data <= fmem[rd_ptr[5:0]];
      rd_ptr       <= rd_ptr + 1;
      pop_total    <= pop_total + 1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] d);
    fmem[wr_ptr[5:0]] = d;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total_cnt++;
    if ({req_ready, fifo_pop, out_valid, out_last, busy, done} !== 6'b0)
      $display("FAIL reset_ctrl got %b exp 000000", {req_ready, fifo_pop, out_valid, out_last, busy, done});
    else pass_cnt++;
    total_cnt++;
    if (out_data !== 32'h0) $display("FAIL reset_data got %h exp 0", out_data);
    else pass_cnt++;
    reset = 1'b1;
    step();
    total_cnt++;
    if ({req_ready, busy} !== 2'b10) $display("FAIL reset_release got %b exp 10", {req_ready, busy});
    else pass_cnt++;
  endtask

  task automatic test_basic();
    logic [31:0] exp_d [3];
    exp_d[0] = 32'hAA; exp_d[1] = 32'hBB; exp_d[2] = 32'hCC;
    push(32'hAA); push(32'hBB); push(32'hCC);
    out_ready = 1'b1;
    req_valid = 1'b1; req_len = 8'd3;
    #1;
    total_cnt++;
    if (req_ready !== 1'b1) $display("FAIL basic_req_ready got %b exp 1", req_ready);
    else pass_cnt++;
    step();
    req_valid = 1'b0;
    #1;
    total_cnt++;
    if ({fifo_pop, busy, out_valid} !== 3'b110) $display("FAIL basic_t1 got %b exp 110", {fifo_pop, busy, out_valid});
    else pass_cnt++;
    step();
    total_cnt++;
    if ({fifo_pop, out_valid} !== 2'b10) $display("FAIL basic_t2 got %b exp 10", {fifo_pop, out_valid});
    else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      step();
      total_cnt++;
      if ({out_valid, out_last, out_data} !== {1'b1, (i == 2), exp_d[i]})
        $display("FAIL basic_word%0d got v=%b l=%b d=%h exp v=1 l=%b d=%h", i, out_valid, out_last, out_data, (i == 2), exp_d[i]);
      else pass_cnt++;
    end
    step();
    total_cnt++;
    if ({done, out_valid, busy} !== 3'b101) $display("FAIL basic_done got %b exp 101", {done, out_valid, busy});
    else pass_cnt++;
    step();
    total_cnt++;
    if ({done, req_ready, busy, fifo_empty} !== 4'b0101)
      $display("FAIL basic_idle got %b exp 0101", {done, req_ready, busy, fifo_empty});
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    logic pat [4];
    int idx = 0;
    int pop_base;
    logic done_seen = 1'b0;
    logic prev_stall = 1'b0;
    logic [31:0] prev_data = '0;
    logic prev_last = 1'b0;
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
    for (int i = 0; i < 8; i++) push(32'h100 + i);
    pop_base = pop_total;
    req_valid = 1'b1; req_len = 8'd8;
    step();
    req_valid = 1'b0;
    for (int c = 0; c < 100; c++) begin
      out_ready = pat[c % 4];
      #1;
      if (prev_stall) begin
        total_cnt++;
        if ({out_valid, out_last, out_data} !== {1'b1, prev_last, prev_data})
          $display("FAIL bp_hold got v=%b l=%b d=%h exp v=1 l=%b d=%h", out_valid, out_last, out_data, prev_last, prev_data);
        else pass_cnt++;
      end
      total_cnt++;
      if ((pop_total - pop_base - idx) > 2) $display("FAIL bp_occ got %0d exp <=2", pop_total - pop_base - idx);
      else pass_cnt++;
      if (out_valid && out_ready) begin
        total_cnt++;
        if ({out_last, out_data} !== {(idx == 7), 32'h100 + idx})
          $display("FAIL bp_word%0d got l=%b d=%h exp l=%b d=%h", idx, out_last, out_data, (idx == 7), 32'h100 + idx);
        else pass_cnt++;
        idx++;
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
      if (done) begin
        done_seen = 1'b1;
        break;
      end
      step();
    end
    out_ready = 1'b1;
    total_cnt++;
    if ({done_seen, idx} !== {1'b1, 32'd8}) $display("FAIL bp_count got done=%b words=%0d exp done=1 words=8", done_seen, idx);
    else pass_cnt++;
    step();
  endtask

  task automatic test_starved();
    int idx = 0;
    logic done_seen = 1'b0;
    push(32'h200); push(32'h201);
    out_ready = 1'b1;
    req_valid = 1'b1; req_len = 8'd5;
    step();
    req_valid = 1'b0;
    for (int c = 0; c < 60; c++) begin
      if (c == 10) begin
        push(32'h202); push(32'h203); push(32'h204);
      end
      #1;
      if (c == 8) begin
        total_cnt++;
        if ({busy, req_ready, fifo_pop, out_valid, fifo_empty} !== 5'b10001)
          $display("FAIL starve_wait got %b exp 10001", {busy, req_ready, fifo_pop, out_valid, fifo_empty});
        else pass_cnt++;
      end
      if (out_valid && out_ready) begin
        total_cnt++;
        if ({out_last, out_data} !== {(idx == 4), 32'h200 + idx})
          $display("FAIL starve_word%0d got l=%b d=%h exp l=%b d=%h", idx, out_last, out_data, (idx == 4), 32'h200 + idx);
        else pass_cnt++;
        idx++;
      end
      if (done) begin
        done_seen = 1'b1;
        break;
      end
      step();
    end
    total_cnt++;
    if ({done_seen, idx, underflow} !== {1'b1, 32'd5, 32'd0})
      $display("FAIL starve_count got done=%b words=%0d underflow=%0d exp 1 5 0", done_seen, idx, underflow);
    else pass_cnt++;
    step();
  endtask

  task automatic test_len0();
    int pop_base;
    for (int i = 0; i < 8; i++) push(32'h400 + i);
    pop_base = pop_total;
    req_valid = 1'b1; req_len = 8'd0;
    #1;
    total_cnt++;
    if (req_ready !== 1'b1) $display("FAIL len0_req_ready got %b exp 1", req_ready);
    else pass_cnt++;
    step();
    req_valid = 1'b0;
    #1;
    total_cnt++;
    if ({done, busy, fifo_pop, req_ready} !== 4'b1100) $display("FAIL len0_t1 got %b exp 1100", {done, busy, fifo_pop, req_ready});
    else pass_cnt++;
    step();
    total_cnt++;
    if ({done, busy, fifo_pop, req_ready} !== 4'b0001) $display("FAIL len0_t2 got %b exp 0001", {done, busy, fifo_pop, req_ready});
    else pass_cnt++;
    total_cnt++;
    if (pop_total !== pop_base) $display("FAIL len0_pops got %0d exp %0d", pop_total, pop_base);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int idx = 0;
    int pop_base;
    logic done_seen = 1'b0;
    pop_base = pop_total;
    out_ready = 1'b1;
    req_valid = 1'b1; req_len = 8'd6;
    step();
    req_valid = 1'b0;
    step();
    step();
    total_cnt++;
    if ({out_valid, out_data} !== {1'b1, 32'h400}) $display("FAIL rst_word0 got v=%b d=%h exp v=1 d=400", out_valid, out_data);
    else pass_cnt++;
    step();
    total_cnt++;
    if ({out_valid, out_data} !== {1'b1, 32'h401}) $display("FAIL rst_word1 got v=%b d=%h exp v=1 d=401", out_valid, out_data);
    else pass_cnt++;
    step();
    reset = 1'b0;
    #1;
    total_cnt++;
    if ({fifo_pop, req_ready} !== 2'b00) $display("FAIL rst_during got %b exp 00", {fifo_pop, req_ready});
    else pass_cnt++;
    step();
    reset = 1'b1;
    #1;
    total_cnt++;
    if ({fifo_pop, out_valid, out_last, busy, done, req_ready, out_data} !== {6'b000001, 32'h0})
      $display("FAIL rst_after got ctrl=%b d=%h exp ctrl=000001 d=0", {fifo_pop, out_valid, out_last, busy, done, req_ready}, out_data);
    else pass_cnt++;
    total_cnt++;
    if (pop_total - pop_base !== 4) $display("FAIL rst_pops got %0d exp 4", pop_total - pop_base);
    else pass_cnt++;
    req_valid = 1'b1; req_len = 8'd2;
    step();
    req_valid = 1'b0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (out_valid && out_ready) begin
        total_cnt++;
        if ({out_last, out_data} !== {(idx == 1), 32'h404 + idx})
          $display("FAIL rst_new_word%0d got l=%b d=%h exp l=%b d=%h", idx, out_last, out_data, (idx == 1), 32'h404 + idx);
        else pass_cnt++;
        idx++;
      end
      if (done) begin
        done_seen = 1'b1;
        break;
      end
      step();
    end
    total_cnt++;
    if ({done_seen, idx} !== {1'b1, 32'd2}) $display("FAIL rst_new_count got done=%b words=%0d exp 1 2", done_seen, idx);
    else pass_cnt++;
    step();
  endtask

  task automatic test_ignore_req();
    int idx = 0;
    int done_cnt = 0;
    push(32'h500); push(32'h501);
    out_ready = 1'b1;
    req_valid = 1'b1; req_len = 8'd2;
    step();
    req_len = 8'd3;
    for (int c = 0; c < 20; c++) begin
      if (c == 5) req_valid = 1'b0;
      #1;
      if (out_valid && out_ready) begin
        total_cnt++;
        if ({out_last, out_data} !== {(idx == 1), 32'h406 + idx})
          $display("FAIL ign_word%0d got l=%b d=%h exp l=%b d=%h", idx, out_last, out_data, (idx == 1), 32'h406 + idx);
        else pass_cnt++;
        idx++;
      end
      if (done) done_cnt++;
      step();
    end
    total_cnt++;
    if ({idx, done_cnt, wr_ptr - rd_ptr} !== {32'd2, 32'd1, 32'd2})
      $display("FAIL ign_count got words=%0d done=%0d left=%0d exp 2 1 2", idx, done_cnt, wr_ptr - rd_ptr);
    else pass_cnt++;
    total_cnt++;
    if ({req_ready, busy, underflow} !== {2'b10, 32'd0})
      $display("FAIL ign_idle got rdy=%b busy=%b uf=%0d exp 1 0 0", req_ready, busy, underflow);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_starved();
    test_len0();
    test_reset_mid();
    test_ignore_req();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
